hawkes_decay_ctrl: RTL

// Intensity-update stage of the Hawkes Monte Carlo datapath, wrapped around the expon unit.

---
 rtl/hawkes_decay_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/hawkes_decay_ctrl.sv
// hawkes_decay_ctrl: intensity-update stage of the Hawkes Monte Carlo datapath.
// Forms the decay exponent x0 = -beta*dt for the expon unit, runs its start/done
// handshake with a timeout, then updates lambda = mu + (lambda - mu)*y (+ alpha)
// and presents the result on a valid/ready output. All data is Q2.8, 10 bits.
module hawkes_decay_ctrl #(
    parameter int W           = 10,
    parameter int FRAC        = 8,
    parameter int EXP_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] mu,
    input  logic [W-1:0] alpha,
    input  logic [W-1:0] beta,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dt,
    input  logic         event_in,
    output logic [W-1:0] exp_x0,
    output logic         exp_start,
    input  logic [W-1:0] exp_y,
    input  logic         exp_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] lambda_out,
    output logic         err
);

    localparam int CW = $clog2(EXP_TIMEOUT + 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARG    = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_OUT    = 3'd5
    } state_t;

    // Clamp the exponent magnitude to 2.0 and negate it into two's complement.
    function automatic logic [W-1:0] neg_sat_x0(input logic [11:0] m);
        logic [W-1:0] mag;
        if (m > 12'd512) begin
            mag = 10'h200;
        end else begin
            mag = m[W-1:0];
        end
        return 10'd0 - mag;
    endfunction

    // Clamp the widened lambda sum to the largest Q2.8 value.
    function automatic logic [W-1:0] sat_lambda(input logic [12:0] s);
        if (s > 13'h03FF) begin
            return 10'h3FF;
        end else begin
            return s[W-1:0];
        end
    endfunction

    state_t          state_r, state_n_s;
    logic            in_ready_r, exp_start_r, out_valid_r, err_r;
    logic [W-1:0]    exp_x0_r, lambda_out_r, lambda_r;
    logic [W-1:0]    mu_r, alpha_r, y_r;
    logic            ev_r;
    logic [CW-1:0]   wait_cnt_r;
    logic            take_y_s, timeout_s;
    logic [19:0]     arg_prod_s;
    logic [11:0]     arg_mag_s;
    logic [W-1:0]    diff_s;
    logic [19:0]     decay_prod_s;
    logic [12:0]     lambda_sum_s;
    logic [W-1:0]    lambda_n_s;

    // Exponent magnitude from the live inputs so x0 is ready as the sample is taken.
    always_comb begin
        arg_prod_s = 20'(beta) * 20'(dt);
        arg_mag_s  = 12'(arg_prod_s >> FRAC);
    end

    // Decayed excess over the base rate plus the optional jump, saturated.
    always_comb begin
        if (lambda_r > mu_r) begin
            diff_s = lambda_r - mu_r;
        end else begin
            diff_s = 10'd0;
        end
        decay_prod_s = 20'(diff_s) * 20'(y_r);
        lambda_sum_s = 13'(mu_r) + 13'(decay_prod_s >> FRAC)
                     + (ev_r ? 13'(alpha_r) : 13'd0);
        lambda_n_s   = sat_lambda(lambda_sum_s);
    end

    // Next-state logic; the first WAIT cycle never looks at exp_done (it may be stale).
    always_comb begin
        state_n_s = state_r;
        take_y_s  = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_n_s = ST_ARG;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ARG:   state_n_s = ST_START;
            ST_START: state_n_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_r == CW'(0)) begin
                    state_n_s = ST_WAIT;
                end else if (exp_done) begin
                    take_y_s  = 1'b1;
                    state_n_s = ST_UPDATE;
                end else if (wait_cnt_r == CW'(EXP_TIMEOUT)) begin
                    timeout_s = 1'b1;
                    state_n_s = ST_UPDATE;
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            ST_UPDATE: state_n_s = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_OUT;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake strobes derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            exp_start_r <= 1'b0;
            out_valid_r <= 1'b0;
            wait_cnt_r  <= '0;
        end else begin
            state_r     <= state_n_s;
            in_ready_r  <= (state_n_s == ST_IDLE);
            exp_start_r <= (state_n_s == ST_START);
            out_valid_r <= (state_n_s == ST_OUT);
            if (state_r == ST_START) begin
                wait_cnt_r <= '0;
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + CW'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Datapath registers: sample capture, expon result, lambda state, sticky fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mu_r         <= 10'd0;
            alpha_r      <= 10'd0;
            ev_r         <= 1'b0;
            exp_x0_r     <= 10'd0;
            y_r          <= 10'd0;
            lambda_r     <= 10'd0;
            lambda_out_r <= 10'd0;
            err_r        <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && in_valid && in_ready_r) begin
                mu_r     <= mu;
                alpha_r  <= alpha;
                ev_r     <= event_in;
                exp_x0_r <= neg_sat_x0(arg_mag_s);
            end
            if (take_y_s) begin
                y_r <= exp_y;
            end else if (timeout_s) begin
                y_r   <= 10'd0;
                err_r <= 1'b1;
            end
            if (state_r == ST_UPDATE) begin
                lambda_r     <= lambda_n_s;
                lambda_out_r <= lambda_n_s;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign exp_start  = exp_start_r;
    assign exp_x0     = exp_x0_r;
    assign out_valid  = out_valid_r;
    assign lambda_out = lambda_out_r;
    assign err        = err_r;

endmodule
